// File: rtl/autoseller_pkg.sv
// Shared types and pricing for the autoseller vending controller.
// State codes are plain constants so legacy tools and waveforms see fixed encodings.
package autoseller_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_CREDIT   = 2'd1;
    localparam state_t ST_DISPENSE = 2'd2;

    typedef enum logic [1:0] {
        STATUS_OK           = 2'd0,
        STATUS_REFUND       = 2'd1,
        STATUS_INSUFFICIENT = 2'd2,
        STATUS_SOLD_OUT     = 2'd3
    } status_e;

    localparam int unsigned PRICE_STEP = 10;

    // The most expensive drink, PRICE_STEP*NUM_TYPES, must fit in the money datapath.
    function automatic int unsigned price(input int unsigned drink_type);
        return PRICE_STEP * (drink_type + 1);
    endfunction

endpackage

// File: rtl/autoseller_stock.sv
// Per-type stock counters with saturating decrement, restock-to-full and empty flags.
// Restock of a type overrides a same-cycle decrement of that type.
module autoseller_stock #(
    parameter int NUM_TYPES  = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 2**STOCK_W - 1,
    parameter int TYPE_W     = $clog2(NUM_TYPES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_i,
    input  logic [TYPE_W-1:0]    dec_type_i,
    input  logic                 restock_i,
    input  logic [TYPE_W-1:0]    restock_type_i,
    output logic [NUM_TYPES-1:0] empty_o
);

    logic [STOCK_W-1:0] stock_q [NUM_TYPES];
    logic [STOCK_W-1:0] stock_d [NUM_TYPES];

    always_comb begin
        for (int t = 0; t < NUM_TYPES; t++) begin
            stock_d[t] = stock_q[t];
            if (restock_i && restock_type_i == TYPE_W'(t)) begin
                stock_d[t] = STOCK_W'(INIT_STOCK);
            end else if (dec_i && dec_type_i == TYPE_W'(t) && stock_q[t] != '0) begin
                stock_d[t] = stock_q[t] - 1'b1;
            end
        end
    end

    // NOTE: the counters are a small register array, not RAM, and are reset because vending starts from a known full stock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TYPES; t++) begin
                stock_q[t] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            for (int t = 0; t < NUM_TYPES; t++) begin
                stock_q[t] <= stock_d[t];
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_TYPES; t++) begin
            empty_o[t] = (stock_q[t] == '0);
        end
    end

endmodule

// File: rtl/autoseller_gen.sv
// Vending controller: accumulates coins, vends or refunds through a one-cycle DISPENSE state.
// All result outputs are registered and read zero outside their enable_o/err_o pulse.
module autoseller_gen
    import autoseller_pkg::*;
#(
    parameter int MONEY_W    = 8,
    parameter int NUM_TYPES  = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 2**STOCK_W - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable_i,
    input  logic [MONEY_W-1:0]           money_i,
    input  logic                         select_i,
    input  logic [$clog2(NUM_TYPES)-1:0] drinktype_i,
    input  logic                         cancel_i,
    input  logic                         restock_i,
    output logic                         ready_o,
    output logic                         enable_o,
    output logic [MONEY_W-1:0]           change_o,
    output logic [$clog2(NUM_TYPES)-1:0] drink_o,
    output logic [1:0]                   status_o,
    output logic                         err_o
);

    localparam int TYPE_W = $clog2(NUM_TYPES);

    state_t              state_q,  state_d;
    logic [MONEY_W-1:0]  credit_q, credit_d;
    logic                enable_q, enable_d;
    logic                err_q,    err_d;
    logic [MONEY_W-1:0]  change_q, change_d;
    logic [TYPE_W-1:0]   drink_q,  drink_d;
    status_e             status_q, status_d;

    logic [NUM_TYPES-1:0] empty;
    logic                 sel_empty;
    logic                 stock_dec;
    logic [MONEY_W:0]     coin_sum;
    logic [MONEY_W-1:0]   price_sel;

    assign coin_sum  = {1'b0, credit_q} + {1'b0, money_i};
    assign price_sel = MONEY_W'(price(32'(drinktype_i)));

    // A type code with no counter behind it reads as sold out.
    always_comb begin
        sel_empty = 1'b1;
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (drinktype_i == TYPE_W'(t)) begin
                sel_empty = empty[t];
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no branch can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        enable_d  = 1'b0;
        err_d     = 1'b0;
        change_d  = '0;
        drink_d   = '0;
        status_d  = STATUS_OK;
        stock_dec = 1'b0;

        if (state_q == ST_DISPENSE) begin
            state_d  = ST_IDLE;
            credit_d = '0;
        end else if (cancel_i) begin
            // Cancel wins arbitration even in IDLE, where it simply has nothing to refund.
            if (state_q == ST_CREDIT) begin
                state_d  = ST_DISPENSE;
                enable_d = 1'b1;
                change_d = credit_q;
                status_d = STATUS_REFUND;
            end
        end else if (select_i) begin
            if (sel_empty) begin
                err_d    = 1'b1;
                status_d = STATUS_SOLD_OUT;
            end else if (credit_q < price_sel) begin
                err_d    = 1'b1;
                status_d = STATUS_INSUFFICIENT;
            end else begin
                state_d   = ST_DISPENSE;
                stock_dec = 1'b1;
                enable_d  = 1'b1;
                change_d  = credit_q - price_sel;
                drink_d   = drinktype_i;
            end
        end else if (enable_i) begin
            if (coin_sum[MONEY_W]) begin
                err_d    = 1'b1;
                status_d = STATUS_INSUFFICIENT;
            end else begin
                credit_d = coin_sum[MONEY_W-1:0];
                state_d  = (coin_sum[MONEY_W-1:0] != '0) ? ST_CREDIT : ST_IDLE;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            enable_q <= 1'b0;
            err_q    <= 1'b0;
            change_q <= '0;
            drink_q  <= '0;
            status_q <= STATUS_OK;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            enable_q <= enable_d;
            err_q    <= err_d;
            change_q <= change_d;
            drink_q  <= drink_d;
            status_q <= status_d;
        end
    end

    autoseller_stock #(
        .NUM_TYPES  (NUM_TYPES),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK),
        .TYPE_W     (TYPE_W)
    ) u_stock (
        .clk            (clk),
        .rst_n          (reset),
        .dec_i          (stock_dec),
        .dec_type_i     (drinktype_i),
        .restock_i      (restock_i),
        .restock_type_i (drinktype_i),
        .empty_o        (empty)
    );

    assign ready_o  = (state_q != ST_DISPENSE);
    assign enable_o = enable_q;
    assign err_o    = err_q;
    assign change_o = change_q;
    assign drink_o  = drink_q;
    assign status_o = status_q;

endmodule

// File: tb/tb_autoseller_gen.sv
// Self-checking bench for autoseller_gen: directed scenarios plus random strobes,
// all compared against a transaction-level model of credit, stock and result pulses.
module tb_autoseller_gen;

    localparam int MONEY_W    = 8;
    localparam int NUM_TYPES  = 4;
    localparam int STOCK_W    = 4;
    localparam int INIT_STOCK = 15;
    localparam int MAX_MONEY  = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_i;
    logic [7:0] money_i;
    logic       select_i;
    logic [1:0] drinktype_i;
    logic       cancel_i;
    logic       restock_i;
    logic       ready_o;
    logic       enable_o;
    logic [7:0] change_o;
    logic [1:0] drink_o;
    logic [1:0] status_o;
    logic       err_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: credit in plain integers, stock per type, expected pulse contents.
    int m_credit;
    bit m_dispensing;
    int m_stock [NUM_TYPES];
    int exp_en, exp_err, exp_change, exp_drink, exp_status;

    always #5 clk = ~clk;

    autoseller_gen #(
        .MONEY_W    (MONEY_W),
        .NUM_TYPES  (NUM_TYPES),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable_i),
        .money_i     (money_i),
        .select_i    (select_i),
        .drinktype_i (drinktype_i),
        .cancel_i    (cancel_i),
        .restock_i   (restock_i),
        .ready_o     (ready_o),
        .enable_o    (enable_o),
        .change_o    (change_o),
        .drink_o     (drink_o),
        .status_o    (status_o),
        .err_o       (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_credit     = 0;
        m_dispensing = 1'b0;
        for (int t = 0; t < NUM_TYPES; t++) m_stock[t] = INIT_STOCK;
        exp_en = 0; exp_err = 0; exp_change = 0; exp_drink = 0; exp_status = 0;
    endtask

    // One accepted-edge worth of behaviour, from the vending rules.
    task automatic model_step(input bit en, input int m, input bit sel, input int ty,
                              input bit can, input bit rs);
        int cost;
        cost = 10 * (ty + 1);
        exp_en = 0; exp_err = 0; exp_change = 0; exp_drink = 0; exp_status = 0;
        if (m_dispensing) begin
            m_dispensing = 1'b0;
            m_credit     = 0;
        end else if (can) begin
            if (m_credit > 0) begin
                exp_en = 1; exp_change = m_credit; exp_status = 1;
                m_dispensing = 1'b1;
            end
        end else if (sel) begin
            if (m_stock[ty] == 0) begin
                exp_err = 1; exp_status = 3;
            end else if (m_credit < cost) begin
                exp_err = 1; exp_status = 2;
            end else begin
                exp_en = 1; exp_change = m_credit - cost; exp_drink = ty;
                m_stock[ty]--;
                m_dispensing = 1'b1;
            end
        end else if (en) begin
            if (m_credit + m > MAX_MONEY) begin
                exp_err = 1; exp_status = 2;
            end else begin
                m_credit += m;
            end
        end
        if (rs) m_stock[ty] = INIT_STOCK;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".enable_o"}, 32'(enable_o), exp_en);
        check({tag, ".err_o"},    32'(err_o),    exp_err);
        check({tag, ".change_o"}, 32'(change_o), exp_change);
        check({tag, ".drink_o"},  32'(drink_o),  exp_drink);
        check({tag, ".status_o"}, 32'(status_o), exp_status);
        check({tag, ".ready_o"},  32'(ready_o),  m_dispensing ? 0 : 1);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
    task automatic step(input string tag, input bit en, input int m, input bit sel,
                        input int ty, input bit can, input bit rs);
        enable_i    = en;
        money_i     = 8'(m);
        select_i    = sel;
        drinktype_i = 2'(ty);
        cancel_i    = can;
        restock_i   = rs;
        model_step(en, m, sel, ty, can, rs);
        @(posedge clk);
        @(negedge clk);
        enable_i = 1'b0; money_i = '0; select_i = 1'b0;
        drinktype_i = '0; cancel_i = 1'b0; restock_i = 1'b0;
        check_outputs(tag);
    endtask

    task automatic coin(input string tag, input int m);
        step(tag, 1'b1, m, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic vend(input string tag, input int ty);
        step(tag, 1'b0, 0, 1'b1, ty, 1'b0, 1'b0);
    endtask

    task automatic cancel(input string tag);
        step(tag, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        enable_i = 1'b0; money_i = '0; select_i = 1'b0;
        drinktype_i = '0; cancel_i = 1'b0; restock_i = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        reset = 1'b1;

        // 10 + 5 is short of 20; one more 5 makes it exact.
        coin("c10", 10);
        coin("c5", 5);
        vend("sel1_short", 1);
        check("sel1_short.status", 32'(status_o), 2);
        coin("c5b", 5);
        vend("sel1_exact", 1);
        check("sel1_exact.enable", 32'(enable_o), 1);
        check("sel1_exact.change", 32'(change_o), 0);
        check("sel1_exact.drink",  32'(drink_o),  1);
        check("sel1_exact.ready",  32'(ready_o),  0);
        idle("after_sel1");

        coin("c30", 30);
        vend("sel0", 0);
        check("sel0.change", 32'(change_o), 20);
        idle("after_sel0");
        cancel("cancel_idle");

        coin("c10_t3", 10);
        vend("sel3_short", 3);
        cancel("refund10");
        check("refund10.change", 32'(change_o), 10);
        check("refund10.status", 32'(status_o), 1);
        idle("after_refund10");

        for (int i = 0; i < INIT_STOCK; i++) begin
            coin("drain_coin", 30);
            vend("drain_sel", 2);
            idle("drain_idle");
        end
        coin("so_coin", 30);
        vend("sold_out", 2);
        check("sold_out.status", 32'(status_o), 3);
        check("sold_out.err",    32'(err_o),    1);
        step("restock2", 1'b0, 0, 1'b0, 2, 1'b0, 1'b1);
        vend("after_restock", 2);
        check("after_restock.enable", 32'(enable_o), 1);
        idle("after_restock_idle");

        coin("ov200", 200);
        coin("ov50", 50);
        coin("ov10", 10);
        check("overflow.err", 32'(err_o), 1);
        cancel("ov_refund");
        check("ov_refund.change", 32'(change_o), 250);
        idle("after_ov");

        coin("cs40", 40);
        step("cancel_sel", 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
        check("cancel_sel.status", 32'(status_o), 1);
        check("cancel_sel.drink",  32'(drink_o),  0);
        idle("after_cancel_sel");

        // Asynchronous reset while the vend pulse is on the outputs.
        coin("rst_coin", 30);
        vend("rst_sel", 0);
        #2 reset = 1'b0;
        #1;
        check("async_rst.enable", 32'(enable_o), 0);
        check("async_rst.change", 32'(change_o), 0);
        check("async_rst.ready",  32'(ready_o),  1);
        model_reset();
        @(negedge clk);
        check_outputs("in_reset");
        reset = 1'b1;
        idle("post_reset");

        for (int i = 0; i < 1500; i++) begin
            bit en, sel, can, rs;
            int m, ty;
            en  = ($urandom_range(0, 1) == 1);
            sel = ($urandom_range(0, 3) == 0);
            can = ($urandom_range(0, 7) == 0);
            rs  = ($urandom_range(0, 39) == 0);
            ty  = $urandom_range(0, NUM_TYPES - 1);
            m   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
            step("rand", en, m, sel, ty, can, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
